cpu_out_display: RTL

//  Consumer end of the CPU output port. Watches AeolusCPUTop.cpuOut and captures each new value once it is stable.

---
 rtl/aeolus_display_pkg.sv | 16 +
 rtl/seg7_decoder.sv | 11 +
 rtl/cpu_out_display.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aeolus_display_pkg.sv
// Shared constants for the CPU output display: digit count, blank pattern and the
// active-low hex to 7-segment table (bit 0 = a ... bit 6 = g).
package aeolus_display_pkg;

  localparam int DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  // Entries packed F..0, so HEX_SEG[n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex digit to active-low 7-segment pattern, driven from the package table.
module seg7_decoder
  import aeolus_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/cpu_out_display.sv
// Captures stable values from the CPU output port, keeps the last four and scans them onto a
// 4-digit multiplexed 7-segment display. Define BLANK_EMPTY_EN to blank digits not yet filled.
module cpu_out_display
  import aeolus_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int STABLE_CYCLES = 2
) (
  input  logic       boardCLK,
  input  logic       resetN,
  input  logic [3:0] cpuOut,
  input  logic       clear,
  output logic [6:0] segments,
  output logic [3:0] anodes,
  output logic       newValue,
  output logic [7:0] captureCount
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SC_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

`ifdef BLANK_EMPTY_EN
  localparam logic [6:0] SEG_RESET = SEG_BLANK;
`else
  localparam logic [6:0] SEG_RESET = HEX_SEG[0];
`endif

  logic [3:0]              cand_q, cand_d;
  logic [SC_W-1:0]         stable_q, stable_d;
  logic                    done_q, done_d;
  logic [DIGITS-1:0][3:0]  hist_q, hist_d;
  logic [DIGITS-1:0]       valid_q, valid_d;
  logic [7:0]              count_q, count_d;
  logic                    new_value_q, new_value_d;
  logic [DIV_W-1:0]        div_q, div_d;
  digit_idx_t              idx_q, idx_d;
  logic [3:0]              anodes_q, anodes_d;
  logic [6:0]              segments_q, segments_d;
  logic                    capture, dup, shift, wrap;
  logic [6:0]              dec_seg;

  seg7_decoder u_dec (
    .hex_i (hist_q[idx_q]),
    .seg_o (dec_seg)
  );

  always_comb begin
    cand_d      = cand_q;
    stable_d    = stable_q;
    done_d      = done_q;
    capture     = 1'b0;
    hist_d      = hist_q;
    valid_d     = valid_q;
    count_d     = count_q;

    if (cpuOut != cand_q) begin
      cand_d   = cpuOut;
      stable_d = '0;
      done_d   = 1'b0;
    end else if (stable_q < SC_W'(STABLE_CYCLES - 1)) begin
      stable_d = stable_q + SC_W'(1);
    end else if (!done_q) begin
      done_d  = 1'b1;
      capture = 1'b1;
    end

    // A repeat of the newest entry still completes the capture but leaves history alone.
    dup   = (cand_q == hist_q[0]) && valid_q[0];
    shift = capture && !dup && !clear;

    if (clear) begin
      hist_d  = '0;
      valid_d = '0;
      count_d = '0;
      done_d  = 1'b1;
    end else if (shift) begin
      hist_d  = {hist_q[DIGITS-2:0], cand_q};
      valid_d = {valid_q[DIGITS-2:0], 1'b1};
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
    new_value_d = shift;

    wrap     = (div_q == DIV_W'(REFRESH_DIV - 1));
    div_d    = wrap ? '0 : div_q + DIV_W'(1);
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    anodes_d = ~(DIGITS'(1) << idx_q);
`ifdef BLANK_EMPTY_EN
    segments_d = valid_q[idx_q] ? dec_seg : SEG_BLANK;
`else
    segments_d = dec_seg;
`endif
  end

  always_ff @(posedge boardCLK or negedge resetN) begin
    if (!resetN) begin
      cand_q      <= '0;
      stable_q    <= '0;
      done_q      <= 1'b0;
      hist_q      <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      new_value_q <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      anodes_q    <= 4'b1110;
      segments_q  <= SEG_RESET;
    end else begin
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      done_q      <= done_d;
      hist_q      <= hist_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      new_value_q <= new_value_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
    end
  end

  assign segments     = segments_q;
  assign anodes       = anodes_q;
  assign newValue     = new_value_q;
  assign captureCount = count_q;

endmodule
